// File: rtl/bids22_cmd_sequencer_pkg.sv
// bids22 shared definitions: bid-master opcodes and error codes, the
// cin/cout bundles of the bid master, and the command-sequencer state set.
package bids22defs;

    localparam int BIDS22_DW = 32;

    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        UNLOCK       = 4'd1,
        LOCK         = 4'd2,
        LOADX        = 4'd3,
        LOADY        = 4'd4,
        LOADZ        = 4'd5,
        SETXVALUE    = 4'd6,
        SETYVALUE    = 4'd7,
        SETBIDCHARGE = 4'd8
    } opcodes_t;

    typedef enum logic [2:0] {
        NOERROR         = 3'd0,
        BADKEY          = 3'd1,
        ALREADYUNLOCKED = 3'd2,
        CANNOTLOCK      = 3'd3,
        INVALID_OP      = 3'd4,
        ALREADYLOCKED   = 3'd5,
        ISLOCKED        = 3'd6
    } outerrors_t;

    // cin of the bid master
    typedef struct packed {
        opcodes_t               C_op;
        logic [BIDS22_DW-1:0]   C_data;
        logic                   C_start;
    } fsminputs_t;

    // cout of the bid master
    typedef struct packed {
        logic                   ready;
        outerrors_t             err;
        logic                   roundOver;
        logic [BIDS22_DW-1:0]   maxBid;
    } fsmoutputs_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CHECK   = 3'd2,
        ARM     = 3'd3,
        ROUND   = 3'd4,
        RESPOND = 3'd5
    } seqstates_t;

    // Opcodes above SETBIDCHARGE are never forwarded to the bid master.
    function automatic logic op_is_valid(input logic [3:0] op);
        return op <= SETBIDCHARGE;
    endfunction

endpackage

// File: rtl/bids22_cmd_sequencer_timer.sv
// bids22_seq_timer: saturating wait counter for the command sequencer.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - zero the counter (wins over enable)
//   enable      - count this cycle
//   expire      - this enabled cycle is the LIMIT-th one since the last clear
module bids22_seq_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] MAX  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    // Flag in the cycle whose increment makes the count reach LIMIT.
    assign expire = enable && (count >= LAST);

endmodule

// File: rtl/bids22_cmd_sequencer.sv
// bids22_cmd_sequencer: turns host requests into timed C_op/C_data/C_start
// sequences for the bid master and returns one response per request.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   req_valid/req_ready           - host request handshake
//   req_op, req_data, req_round   - opcode, operand, run a round afterwards
//   rsp_valid/rsp_ready           - host response handshake
//   rsp_err, rsp_maxbid, rsp_timeout - captured result of the request
//   c_op, c_data, c_start         - cin of the bid master (registered)
//   s_ready, s_err, s_roundover, s_maxbid - cout of the bid master
module bids22_cmd_sequencer
    import bids22defs::*;
#(
    parameter int DATAWIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [DATAWIDTH-1:0] req_data,
    input  logic                 req_round,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_err,
    output logic [DATAWIDTH-1:0] rsp_maxbid,
    output logic                 rsp_timeout,
    output logic [DATAWIDTH-1:0] c_data,
    output logic [3:0]           c_op,
    output logic                 c_start,
    input  logic                 s_ready,
    input  logic [2:0]           s_err,
    input  logic                 s_roundover,
    input  logic [DATAWIDTH-1:0] s_maxbid
);

    seqstates_t           state, next_state;
    logic                 round_q;
    logic [2:0]           err_n;
    logic [DATAWIDTH-1:0] maxbid_n;
    logic                 timeout_n;
    logic                 expire;

    assign req_ready = (state == IDLE) && !reset;

    always_comb begin
        next_state = state;
        err_n      = NOERROR;
        maxbid_n   = '0;
        timeout_n  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (!op_is_valid(req_op)) begin
                        next_state = RESPOND;
                        err_n      = INVALID_OP;
                    end else if (req_op != NO_OP) begin
                        next_state = ISSUE;
                    end else if (req_round) begin
                        next_state = ARM;
                    end else begin
                        next_state = RESPOND;
                    end
                end
            end
            ISSUE: next_state = CHECK;
            CHECK: begin
                if ((s_err != NOERROR) || !round_q) begin
                    next_state = RESPOND;
                    err_n      = s_err;
                end else begin
                    next_state = ARM;
                end
            end
            ARM: begin
                if (s_ready) begin
                    next_state = ROUND;
                end else if (expire) begin
                    next_state = RESPOND;
                    timeout_n  = 1'b1;
                end
            end
            ROUND: begin
                // roundover is checked first so it beats a same-cycle timeout
                if (s_roundover) begin
                    next_state = RESPOND;
                    maxbid_n   = s_maxbid;
                    err_n      = s_err;
                end else if (expire) begin
                    next_state = RESPOND;
                    timeout_n  = 1'b1;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so each one lines up with the
    // cycle its state is occupied; c_op/c_data double as the op/data latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            round_q     <= 1'b0;
            c_op        <= NO_OP;
            c_data      <= '0;
            c_start     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= NOERROR;
            rsp_maxbid  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state     <= next_state;
            c_op      <= (next_state == ISSUE) ? req_op : NO_OP;
            c_data    <= (next_state == ISSUE) ? req_data : '0;
            c_start   <= (next_state == ROUND);
            rsp_valid <= (next_state == RESPOND);
            if (req_valid && req_ready) begin
                round_q <= req_round;
            end
            if ((next_state == RESPOND) && (state != RESPOND)) begin
                rsp_err     <= err_n;
                rsp_maxbid  <= maxbid_n;
                rsp_timeout <= timeout_n;
            end
        end
    end

    // Every state change restarts the wait count, so ARM and ROUND each
    // begin from zero.
    bids22_seq_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (next_state != state),
        .enable ((state == ARM) || (state == ROUND)),
        .expire (expire)
    );

endmodule

// File: tb/tb_bids22_cmd_sequencer.sv
// Self-checking bench for bids22_cmd_sequencer: a table of request vectors
// with hand-computed responses, plus hand-written reset and back-pressure
// sequences. The bench plays the bid master on a cycle schedule counted
// from the cycle the request is accepted (cycle 0).
module tb_bids22_cmd_sequencer;
    import bids22defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_data;
    logic        req_round;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_err;
    logic [31:0] rsp_maxbid;
    logic        rsp_timeout;
    logic [31:0] c_data;
    logic [3:0]  c_op;
    logic        c_start;
    logic        s_ready;
    logic [2:0]  s_err;
    logic        s_roundover;
    logic [31:0] s_maxbid;

    int n_cmp = 0;
    int n_bad = 0;

    bids22_cmd_sequencer #(
        .DATAWIDTH      (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .req_round   (req_round),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_err     (rsp_err),
        .rsp_maxbid  (rsp_maxbid),
        .rsp_timeout (rsp_timeout),
        .c_data      (c_data),
        .c_op        (c_op),
        .c_start     (c_start),
        .s_ready     (s_ready),
        .s_err       (s_err),
        .s_roundover (s_roundover),
        .s_maxbid    (s_maxbid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] data;
        logic        round;
        logic [2:0]  err_chk;    // s_err in cycle 2
        int          rdy_at;     // s_ready high from this cycle on (0: never)
        int          ro_at;      // s_roundover pulse cycle (0: never)
        logic [2:0]  ro_err;     // s_err in the roundover cycle
        logic [31:0] maxbid;     // s_maxbid in the roundover cycle
        int          exp_lat;    // first cycle with rsp_valid
        logic [2:0]  exp_err;
        logic [31:0] exp_mb;
        logic        exp_to;
        int          exp_drive;  // cycles with c_op/c_data non-zero
        int          exp_start;  // cycles with c_start high
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_op      = 4'd0;
        req_data    = '0;
        req_round   = 1'b0;
        s_ready     = 1'b0;
        s_err       = NOERROR;
        s_roundover = 1'b0;
        s_maxbid    = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat = 0;
        int drives = 0;
        int starts = 0;
        @(negedge clk);
        check($sformatf("v%0d req_ready", idx), req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_data  = v.data;
        req_round = v.round;
        rsp_ready = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c_start) starts++;
            if ((c_op != 4'd0) || (c_data != 32'd0)) drives++;
            if ((n == 1) && (v.exp_drive == 1)) begin
                check($sformatf("v%0d c_op", idx), c_op, v.op);
                check($sformatf("v%0d c_data", idx), c_data, v.data);
            end
            if (rsp_valid) begin
                lat = n;
                break;
            end
            s_ready     = (v.rdy_at != 0) && (n >= v.rdy_at);
            s_roundover = (n == v.ro_at);
            s_maxbid    = (n == v.ro_at) ? v.maxbid : 32'hDEAD_BEEF;
            s_err       = (n == 2) ? v.err_chk : ((n == v.ro_at) ? v.ro_err : 3'(NOERROR));
        end
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
        check($sformatf("v%0d rsp_maxbid", idx), rsp_maxbid, v.exp_mb);
        check($sformatf("v%0d rsp_timeout", idx), rsp_timeout, v.exp_to);
        check($sformatf("v%0d drive cycles", idx), drives, v.exp_drive);
        check($sformatf("v%0d c_start cycles", idx), starts, v.exp_start);
        idle_inputs();
        @(negedge clk);
        check($sformatf("v%0d rsp_valid drop", idx), rsp_valid, 1'b0);
        check($sformatf("v%0d back to idle", idx), req_ready, 1'b1);
        check($sformatf("v%0d c_start low", idx), c_start, 1'b0);
    endtask

    initial begin
        int seen;
        //          op  data     rnd err_chk  rdy ro ro_err  maxbid  lat exp_err  exp_mb  to drv st
        vecs[0]  = '{LOADX, 32'd1000000, 1'b0, NOERROR, 0, 0, NOERROR, 32'd0, 3, NOERROR, 32'd0, 1'b0, 1, 0};
        vecs[1]  = '{UNLOCK, 32'd12, 1'b1, BADKEY, 0, 0, NOERROR, 32'd0, 3, BADKEY, 32'd0, 1'b0, 1, 0};
        vecs[2]  = '{NO_OP, 32'd0, 1'b1, NOERROR, 3, 7, NOERROR, 32'd2, 8, NOERROR, 32'd2, 1'b0, 0, 4};
        vecs[3]  = '{NO_OP, 32'd0, 1'b1, NOERROR, 0, 0, NOERROR, 32'd0, 65, NOERROR, 32'd0, 1'b1, 0, 0};
        vecs[4]  = '{4'hF, 32'd55, 1'b1, NOERROR, 0, 0, NOERROR, 32'd0, 1, INVALID_OP, 32'd0, 1'b0, 0, 0};
        vecs[5]  = '{4'h9, 32'd7, 1'b0, NOERROR, 0, 0, NOERROR, 32'd0, 1, INVALID_OP, 32'd0, 1'b0, 0, 0};
        vecs[6]  = '{NO_OP, 32'd0, 1'b0, NOERROR, 0, 0, NOERROR, 32'd0, 1, NOERROR, 32'd0, 1'b0, 0, 0};
        vecs[7]  = '{SETBIDCHARGE, 32'd5, 1'b1, NOERROR, 3, 5, NOERROR, 32'd77, 6, NOERROR, 32'd77, 1'b0, 1, 2};
        vecs[8]  = '{NO_OP, 32'd0, 1'b1, NOERROR, 1, 0, NOERROR, 32'd0, 66, NOERROR, 32'd0, 1'b1, 0, 64};
        vecs[9]  = '{NO_OP, 32'd0, 1'b1, NOERROR, 1, 65, NOERROR, 32'd9, 66, NOERROR, 32'd9, 1'b0, 0, 64};
        vecs[10] = '{LOCK, 32'h0000_00AB, 1'b1, NOERROR, 3, 4, CANNOTLOCK, 32'h1234_5678, 5, CANNOTLOCK, 32'h1234_5678, 1'b0, 1, 1};

        idle_inputs();
        rsp_ready = 1'b1;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", req_ready, 1'b0);
        check("reset c_op", c_op, NO_OP);
        check("reset c_data", c_data, 32'd0);
        check("reset c_start", c_start, 1'b0);
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset rsp_err", rsp_err, NOERROR);
        check("reset rsp_maxbid", rsp_maxbid, 32'd0);
        check("reset rsp_timeout", rsp_timeout, 1'b0);
        reset = 1'b0;
        #1;
        check("post-reset req_ready", req_ready, 1'b1);
        check("post-reset rsp_valid", rsp_valid, 1'b0);

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a round: no response may follow.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = NO_OP;
        req_round = 1'b1;
        s_ready   = 1'b1;
        seen      = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c_start) break;
        end
        check("midreset c_start seen", c_start, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset req_ready", req_ready, 1'b0);
        @(negedge clk);
        check("midreset c_start", c_start, 1'b0);
        check("midreset rsp_valid", rsp_valid, 1'b0);
        reset       = 1'b0;
        s_roundover = 1'b1;
        s_maxbid    = 32'd99;
        #1;
        check("midreset idle", req_ready, 1'b1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            s_roundover = 1'b0;
            if (rsp_valid || c_start) seen++;
        end
        check("midreset no response", seen, 0);
        idle_inputs();

        // Response back-pressure: rsp_* must hold while rsp_ready is low.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = UNLOCK;
        req_data  = 32'd12;
        req_round = 1'b0;
        rsp_ready = 1'b0;
        seen      = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                seen = n;
                break;
            end
            s_err = (n == 2) ? 3'(BADKEY) : 3'(NOERROR);
        end
        s_err = NOERROR;
        check("hold latency", seen, 3);
        for (int n = 0; n < 5; n++) begin
            check($sformatf("hold%0d rsp_valid", n), rsp_valid, 1'b1);
            check($sformatf("hold%0d rsp_err", n), rsp_err, BADKEY);
            check($sformatf("hold%0d rsp_maxbid", n), rsp_maxbid, 32'd0);
            check($sformatf("hold%0d rsp_timeout", n), rsp_timeout, 1'b0);
            check($sformatf("hold%0d req_ready", n), req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release rsp_valid", rsp_valid, 1'b0);
        check("release req_ready", req_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
